// File: rtl/mult_add_arbiter_if.sv
// Handshake bundle between two requesters, the shared multiply-adder and its result consumer.
// The per-request subtract flags exist only when MULT_ADD_ARB_SUB_EN is defined.
interface mult_add_arbiter_if #(
   parameter int WIDTH = 8
);
   logic                 req0_valid;
   logic                 req0_ready;
   logic [WIDTH-1:0]     req0_a;
   logic [WIDTH-1:0]     req0_b;
   logic [WIDTH-1:0]     req0_c;
   logic                 req1_valid;
   logic                 req1_ready;
   logic [WIDTH-1:0]     req1_a;
   logic [WIDTH-1:0]     req1_b;
   logic [WIDTH-1:0]     req1_c;
   logic                 res_valid;
   logic                 res_ready;
   logic [2*WIDTH-1:0]   res;
   logic                 res_id;
   logic                 busy;
`ifdef MULT_ADD_ARB_SUB_EN
   logic                 req0_sub;
   logic                 req1_sub;
`endif

   modport master (
      output req0_valid, req0_a, req0_b, req0_c,
      output req1_valid, req1_a, req1_b, req1_c,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res, res_id, busy
`ifdef MULT_ADD_ARB_SUB_EN
      , output req0_sub, req1_sub
`endif
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_c,
      input  req1_valid, req1_a, req1_b, req1_c,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res, res_id, busy
`ifdef MULT_ADD_ARB_SUB_EN
      , input req0_sub, req1_sub
`endif
   );
endinterface

// File: rtl/mult_add_arbiter.sv
// Round-robin front end sharing one 3-stage multiply-adder (A*B+C) between two requesters.
// Define MULT_ADD_ARB_SUB_EN to add per-request subtract (A*B-C) support.
module mult_add_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   mult_add_arbiter_if.slave  bus_io
);
   localparam int RW = 2 * WIDTH;

   typedef enum logic {
      PRIO_REQ0 = 1'b0,
      PRIO_REQ1 = 1'b1
   } prio_e;

   prio_e             prio_q, prio_d;

   logic              adv;
   logic              winner;
   logic              ready0;
   logic              ready1;
   logic              accept;
   logic [WIDTH-1:0]  winA, winB, winC;
   logic              winSub;

   logic              s1Valid_q, s1Valid_d;
   logic [WIDTH-1:0]  s1A_q, s1A_d;
   logic [WIDTH-1:0]  s1B_q, s1B_d;
   logic [WIDTH-1:0]  s1C_q, s1C_d;
   logic              s1Id_q, s1Id_d;
   logic              s1Sub_q, s1Sub_d;

   logic              s2Valid_q, s2Valid_d;
   logic [WIDTH-1:0]  s2A_q, s2A_d;
   logic [WIDTH-1:0]  s2B_q, s2B_d;
   logic [WIDTH-1:0]  s2C_q, s2C_d;
   logic              s2Id_q, s2Id_d;
   logic              s2Sub_q, s2Sub_d;

   logic              resValid_q, resValid_d;
   logic [RW-1:0]     res_q, res_d;
   logic              resId_q, resId_d;

   logic [RW-1:0]     product;
   logic [RW-1:0]     cExt;
   logic [RW-1:0]     arith;

   // Readies are forced low while reset is held so no request is acknowledged and then discarded.
   always_comb begin
      adv = !resValid_q || bus_io.res_ready;
      if (bus_io.req0_valid && bus_io.req1_valid) begin
         winner = (prio_q == PRIO_REQ1);
      end else begin
         winner = bus_io.req1_valid;
      end
      ready0 = !rst_i && adv && !winner && bus_io.req0_valid;
      ready1 = !rst_i && adv && winner && bus_io.req1_valid;
      accept = ready0 || ready1;
      winA   = winner ? bus_io.req1_a : bus_io.req0_a;
      winB   = winner ? bus_io.req1_b : bus_io.req0_b;
      winC   = winner ? bus_io.req1_c : bus_io.req0_c;
`ifdef MULT_ADD_ARB_SUB_EN
      winSub = winner ? bus_io.req1_sub : bus_io.req0_sub;
`else
      winSub = 1'b0;
`endif
      prio_d = prio_q;
      if (accept) begin
         prio_d = winner ? PRIO_REQ0 : PRIO_REQ1;
      end
   end

   always_comb begin
      product = {{WIDTH{1'b0}}, s2A_q} * {{WIDTH{1'b0}}, s2B_q};
      cExt    = {{WIDTH{1'b0}}, s2C_q};
      arith   = s2Sub_q ? (product - cExt) : (product + cExt);
   end

   // Whole pipeline moves as one; the result register only reloads for real operations.
   always_comb begin
      s1Valid_d  = s1Valid_q;
      s1A_d      = s1A_q;
      s1B_d      = s1B_q;
      s1C_d      = s1C_q;
      s1Id_d     = s1Id_q;
      s1Sub_d    = s1Sub_q;
      s2Valid_d  = s2Valid_q;
      s2A_d      = s2A_q;
      s2B_d      = s2B_q;
      s2C_d      = s2C_q;
      s2Id_d     = s2Id_q;
      s2Sub_d    = s2Sub_q;
      resValid_d = resValid_q;
      res_d      = res_q;
      resId_d    = resId_q;
      if (adv) begin
         s1Valid_d = accept;
         if (accept) begin
            s1A_d   = winA;
            s1B_d   = winB;
            s1C_d   = winC;
            s1Id_d  = winner;
            s1Sub_d = winSub;
         end
         s2Valid_d  = s1Valid_q;
         s2A_d      = s1A_q;
         s2B_d      = s1B_q;
         s2C_d      = s1C_q;
         s2Id_d     = s1Id_q;
         s2Sub_d    = s1Sub_q;
         resValid_d = s2Valid_q;
         if (s2Valid_q) begin
            res_d   = arith;
            resId_d = s2Id_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q     <= PRIO_REQ0;
         s1Valid_q  <= 1'b0;
         s1A_q      <= '0;
         s1B_q      <= '0;
         s1C_q      <= '0;
         s1Id_q     <= 1'b0;
         s1Sub_q    <= 1'b0;
         s2Valid_q  <= 1'b0;
         s2A_q      <= '0;
         s2B_q      <= '0;
         s2C_q      <= '0;
         s2Id_q     <= 1'b0;
         s2Sub_q    <= 1'b0;
         resValid_q <= 1'b0;
         res_q      <= '0;
         resId_q    <= 1'b0;
      end else begin
         prio_q     <= prio_d;
         s1Valid_q  <= s1Valid_d;
         s1A_q      <= s1A_d;
         s1B_q      <= s1B_d;
         s1C_q      <= s1C_d;
         s1Id_q     <= s1Id_d;
         s1Sub_q    <= s1Sub_d;
         s2Valid_q  <= s2Valid_d;
         s2A_q      <= s2A_d;
         s2B_q      <= s2B_d;
         s2C_q      <= s2C_d;
         s2Id_q     <= s2Id_d;
         s2Sub_q    <= s2Sub_d;
         resValid_q <= resValid_d;
         res_q      <= res_d;
         resId_q    <= resId_d;
      end
   end

   assign bus_io.req0_ready = ready0;
   assign bus_io.req1_ready = ready1;
   assign bus_io.res_valid  = resValid_q;
   assign bus_io.res        = res_q;
   assign bus_io.res_id     = resId_q;
   assign bus_io.busy       = s1Valid_q || s2Valid_q || resValid_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(ready0 && ready1));
         assert (adv || !accept);
      end
   end
`endif
endmodule

// File: tb/tb_mult_add_arbiter.sv
// Scoreboard bench for mult_add_arbiter: expected results queued on acceptance, checked on drain.
// Compile with MULT_ADD_ARB_SUB_EN defined to also exercise subtract operations.
module tb_mult_add_arbiter;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mult_add_arbiter_if #(.WIDTH(WIDTH)) bus ();

   mult_add_arbiter #(.WIDTH(WIDTH)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   typedef struct packed {
      logic [15:0] res;
      logic        id;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;
   logic mV1, mV2, mV3, mPrio;

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic sub);
      logic [15:0] p;
      logic        doSub;
      doSub = sub;
`ifndef MULT_ADD_ARB_SUB_EN
      doSub = 1'b0;
`endif
      p = 16'(a) * 16'(b);
      return doSub ? (p - 16'(c)) : (p + 16'(c));
   endfunction

   task automatic clearModel();
      mV1   = 1'b0;
      mV2   = 1'b0;
      mV3   = 1'b0;
      mPrio = 1'b0;
      expQ.delete();
   endtask

   // One clock cycle: drive, check handshakes and drained results against the model, then advance.
   task automatic applyStimulus(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                                input logic [7:0] c0, input logic s0,
                                input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                                input logic [7:0] c1, input logic s1,
                                input logic rr, output logic [1:0] grant);
      logic mAdv, mWin, e0, e1;
      exp_t ex;
      bus.req0_valid = v0;
      bus.req0_a     = a0;
      bus.req0_b     = b0;
      bus.req0_c     = c0;
      bus.req1_valid = v1;
      bus.req1_a     = a1;
      bus.req1_b     = b1;
      bus.req1_c     = c1;
      bus.res_ready  = rr;
`ifdef MULT_ADD_ARB_SUB_EN
      bus.req0_sub   = s0;
      bus.req1_sub   = s1;
`endif
      #1;
      mAdv  = !mV3 || rr;
      mWin  = (v0 && v1) ? mPrio : v1;
      e0    = mAdv && !mWin && v0;
      e1    = mAdv && mWin && v1;
      grant = {bus.req1_ready, bus.req0_ready};
      total++;
      if (grant !== {e1, e0}) begin
         bad++;
         $display("[TB] FAIL grant: got %b expected %b", grant, {e1, e0});
      end
      total++;
      if (bus.res_valid !== mV3) begin
         bad++;
         $display("[TB] FAIL res_valid: got %b expected %b", bus.res_valid, mV3);
      end
      total++;
      if (bus.busy !== (mV1 | mV2 | mV3)) begin
         bad++;
         $display("[TB] FAIL busy: got %b expected %b", bus.busy, mV1 | mV2 | mV3);
      end
      if (mV3 && rr && expQ.size() > 0) begin
         ex = expQ.pop_front();
         total++;
         if ({bus.res, bus.res_id} !== {ex.res, ex.id}) begin
            bad++;
            $display("[TB] FAIL result: got res=%0d id=%b expected res=%0d id=%b",
                     bus.res, bus.res_id, ex.res, ex.id);
         end
      end
      if (e0) begin
         ex.res = model(a0, b0, c0, s0);
         ex.id  = 1'b0;
         expQ.push_back(ex);
      end
      if (e1) begin
         ex.res = model(a1, b1, c1, s1);
         ex.id  = 1'b1;
         expQ.push_back(ex);
      end
      if (e0 || e1) mPrio = !mWin;
      if (mAdv) begin
         mV3 = mV2;
         mV2 = mV1;
         mV1 = e0 || e1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic rr);
      logic [1:0] g;
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, rr, g);
      end
   endtask

   task automatic test_reset();
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.res_ready  = 1'b1;
      #1;
      total++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL reset_ready_early: got %b expected 00", {bus.req1_ready, bus.req0_ready});
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL reset_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready});
      end
      rst            = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      clearModel();
      #1;
      total++;
      if ({bus.res_valid, bus.busy, bus.res, bus.res_id} !== {1'b0, 1'b0, 16'd0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL reset_state: got valid=%b busy=%b res=%0d id=%b expected all 0",
                  bus.res_valid, bus.busy, bus.res, bus.res_id);
      end
   endtask

   task automatic test_contention();
      logic [1:0] g;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 8'(i * 3 + 1), 8'(i + 7), 8'(i * 11), 1'b0,
                       1'b1, 8'(i * 5 + 2), 8'(200 - i), 8'(i * 13 + 3), 1'b0, 1'b1, g);
         total++;
         if (g !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
            bad++;
            $display("[TB] FAIL contention_order: cycle %0d got %b expected %b",
                     i, g, (i % 2 == 0) ? 2'b01 : 2'b10);
         end
      end
      idle(4, 1'b1);
   endtask

   task automatic test_single();
      logic [1:0] g;
      applyStimulus(1'b1, 8'd12, 8'd10, 8'd5, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, g);
      idle(2, 1'b1);
      total++;
      if ({bus.res_valid, bus.res, bus.res_id} !== {1'b1, 16'd125, 1'b0}) begin
         bad++;
         $display("[TB] FAIL single_latency: got valid=%b res=%0d id=%b expected 1/125/0",
                  bus.res_valid, bus.res, bus.res_id);
      end
      idle(1, 1'b1);
      total++;
      if (bus.res_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_pulse: got res_valid=%b expected 0", bus.res_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] g;
      applyStimulus(1'b1, 8'd3, 8'd4, 8'd5, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, g);
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 8'd6, 8'd7, 8'd8, 1'b0, 1'b0, g);
      applyStimulus(1'b1, 8'd9, 8'd10, 8'd11, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, g);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'd20, 8'd21, 8'd22, 1'b0, 1'b1, 8'd30, 8'd31, 8'd32, 1'b0, 1'b0, g);
         total++;
         if ({bus.res_valid, bus.res, bus.res_id} !== {1'b1, expQ[0].res, expQ[0].id}) begin
            bad++;
            $display("[TB] FAIL stall_hold: got valid=%b res=%0d id=%b expected 1/%0d/%b",
                     bus.res_valid, bus.res, bus.res_id, expQ[0].res, expQ[0].id);
         end
      end
      applyStimulus(1'b1, 8'd20, 8'd21, 8'd22, 1'b0, 1'b1, 8'd30, 8'd31, 8'd32, 1'b0, 1'b1, g);
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 8'd30, 8'd31, 8'd32, 1'b0, 1'b1, g);
      idle(6, 1'b1);
   endtask

   task automatic test_boundary();
      logic [1:0] g;
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 1'b0, 1'b1, g);
      idle(2, 1'b1);
      total++;
      if ({bus.res_valid, bus.res, bus.res_id} !== {1'b1, 16'd65280, 1'b1}) begin
         bad++;
         $display("[TB] FAIL max_operands: got valid=%b res=%0d id=%b expected 1/65280/1",
                  bus.res_valid, bus.res, bus.res_id);
      end
      idle(1, 1'b1);
`ifdef MULT_ADD_ARB_SUB_EN
      applyStimulus(1'b1, 8'd0, 8'd0, 8'd1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, g);
      idle(2, 1'b1);
      total++;
      if ({bus.res_valid, bus.res, bus.res_id} !== {1'b1, 16'hFFFF, 1'b0}) begin
         bad++;
         $display("[TB] FAIL sub_wrap: got valid=%b res=%h id=%b expected 1/ffff/0",
                  bus.res_valid, bus.res, bus.res_id);
      end
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 8'd10, 8'd10, 8'd7, 1'b1, 1'b1, g);
      idle(3, 1'b1);
`endif
   endtask

   task automatic test_streaming();
      logic [1:0] g;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 8'(i + 40), 8'(i + 2), 8'(i), 1'b0, 1'b1, g);
         total++;
         if (g !== 2'b10) begin
            bad++;
            $display("[TB] FAIL stream_req1: cycle %0d got %b expected 10", i, g);
         end
      end
      applyStimulus(1'b1, 8'd17, 8'd19, 8'd23, 1'b0, 1'b1, 8'd50, 8'd3, 8'd1, 1'b0, 1'b1, g);
      total++;
      if (g !== 2'b01) begin
         bad++;
         $display("[TB] FAIL stream_req0_first: got %b expected 01", g);
      end
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 8'd50, 8'd3, 8'd1, 1'b0, 1'b1, g);
      idle(4, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [1:0] g;
      applyStimulus(1'b1, 8'd100, 8'd2, 8'd9, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, g);
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 8'd77, 8'd3, 8'd4, 1'b0, 1'b1, g);
      rst            = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      total++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL midreset_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready});
      end
      @(posedge clk);
      @(negedge clk);
      rst            = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      clearModel();
      #1;
      total++;
      if ({bus.res_valid, bus.busy} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL midreset_flush: got valid=%b busy=%b expected 0/0", bus.res_valid, bus.busy);
      end
      idle(3, 1'b1);
      applyStimulus(1'b1, 8'd5, 8'd6, 8'd7, 1'b0, 1'b1, 8'd8, 8'd9, 8'd10, 1'b0, 1'b1, g);
      total++;
      if (g !== 2'b01) begin
         bad++;
         $display("[TB] FAIL midreset_prio: got %b expected 01", g);
      end
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 8'd8, 8'd9, 8'd10, 1'b0, 1'b1, g);
      idle(4, 1'b1);
   endtask

   initial begin
      rst            = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req0_a     = '0;
      bus.req0_b     = '0;
      bus.req0_c     = '0;
      bus.req1_valid = 1'b0;
      bus.req1_a     = '0;
      bus.req1_b     = '0;
      bus.req1_c     = '0;
      bus.res_ready  = 1'b0;
`ifdef MULT_ADD_ARB_SUB_EN
      bus.req0_sub   = 1'b0;
      bus.req1_sub   = 1'b0;
`endif
      clearModel();
      test_reset();
      test_contention();
      test_single();
      test_backpressure();
      test_boundary();
      test_streaming();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
